// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift-register serial link receive path.
// Contents: receiver FSM state enum, shift-direction constants and a helper
// that sizes the frame bit counter.
// Optional feature macro: PARITY_CHECK_EN (adds the PARITY state).
package shift_reg_pkg;

    // Receiver FSM states; PARITY exists only when the trailer bit is checked.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
`ifdef PARITY_CHECK_EN
        ST_PARITY = 2'd2,
`endif
        ST_SHIFT  = 2'd1
    } rx_state_e;

    // shift_dir encoding, latched at frame start.
    localparam logic DIR_MSB_FIRST = 1'b0;  // shift left, new bit into LSB
    localparam logic DIR_LSB_FIRST = 1'b1;  // shift right, new bit into MSB

    // Counter must hold 0..width inclusive.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_in_core.sv
// WIDTH-bit bidirectional shift register with clear and shift enable.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   clr           - start from an all-zero register this cycle
//   shift_en      - shift din in this cycle
//   dir           - DIR_MSB_FIRST: shift left into LSB; DIR_LSB_FIRST: shift right into MSB
//   din           - serial bit to insert
//   data_next_c   - combinational next register value (the word including this cycle's bit)
module shift_in_core
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             din,
    output logic [WIDTH-1:0] data_next_c
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] base_c;

    // Next value: optional clear, then optional one-bit shift.
    always_comb begin
        base_c = clr ? '0 : data_q;
        data_d = base_c;
        if (shift_en) begin
            if (dir == DIR_MSB_FIRST) begin
                data_d = {base_c[WIDTH-2:0], din};
            end else begin
                data_d = {din, base_c[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_next_c = data_d;

endmodule

// File: rtl/serial_in_parallel_out_rx.sv
// Serial-in / parallel-out receiver: collects WIDTH bits, one per serial_valid
// strobe, MSB-first or LSB-first, and offers the word on a valid/ready port.
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset
//   serial_in      - serial data bit
//   serial_valid   - serial_in valid this cycle
//   frame_start    - first bit of a frame (honoured only with serial_valid)
//   shift_dir      - 0 MSB-first, 1 LSB-first; sampled at frame start
//   q, q_valid     - received word and its valid flag
//   q_ready        - consumer accepts q when q_valid
//   busy           - frame in progress
//   overrun        - sticky: a completed word was dropped; cleared on handshake
//   parity_err     - one-cycle pulse on bad even parity (0 unless PARITY_CHECK_EN)
// Optional feature macro: PARITY_CHECK_EN (one even-parity trailer bit per frame).
module serial_in_parallel_out_rx
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             frame_start,
    input  logic             shift_dir,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int unsigned         CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(WIDTH - 1);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q_valid_q, q_valid_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             parity_err_q, parity_err_d;

    logic             start_c;
    logic             last_c;
    logic             accept_c;
    logic             shift_en_c;
    logic             core_dir_c;
    logic             complete_c;
    logic [WIDTH-1:0] word_c;

    assign start_c  = serial_valid & frame_start;
    assign last_c   = (cnt_q == LAST_CNT);
    assign accept_c = q_valid_q & q_ready;

    // Direction is taken live on the start bit, latched for the rest of the frame.
    assign core_dir_c = start_c ? shift_dir : dir_q;
    assign shift_en_c = serial_valid & (start_c | (state_q == ST_SHIFT));

    shift_in_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr         (start_c),
        .shift_en    (shift_en_c),
        .dir         (core_dir_c),
        .din         (serial_in),
        .data_next_c (word_c)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a start strobe restarts the frame from any state.
    always_comb begin
        state_d = state_q;
        if (start_c) begin
            state_d = ST_SHIFT;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_SHIFT: begin
                    if (serial_valid && last_c) begin
`ifdef PARITY_CHECK_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
`ifdef PARITY_CHECK_EN
                ST_PARITY: begin
                    if (serial_valid) begin
                        state_d = ST_IDLE;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath / output next values: counter, completion and handshake.
    always_comb begin
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        q_d          = q_q;
        q_valid_d    = q_valid_q;
        overrun_d    = overrun_q;
        parity_err_d = 1'b0;
        complete_c   = 1'b0;

        if (start_c) begin
            cnt_d = CNT_W'(1);
            dir_d = shift_dir;
        end else if (serial_valid) begin
            case (state_q)
                ST_SHIFT: begin
                    if (last_c) begin
                        cnt_d = '0;
`ifndef PARITY_CHECK_EN
                        complete_c = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef PARITY_CHECK_EN
                // Register holds the full word here; even parity over data + trailer.
                ST_PARITY: begin
                    if ((^word_c ^ serial_in) == 1'b0) begin
                        complete_c = 1'b1;
                    end else begin
                        parity_err_d = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end

        // Consume first, so a same-cycle completion can reuse the slot.
        if (accept_c) begin
            q_valid_d = 1'b0;
            overrun_d = 1'b0;
        end
        if (complete_c) begin
            if (!q_valid_q || accept_c) begin
                q_d       = word_c;
                q_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            dir_q        <= DIR_MSB_FIRST;
            q_q          <= '0;
            q_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            q_q          <= q_d;
            q_valid_q    <= q_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign q          = q_q;
    assign q_valid    = q_valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
    assign parity_err = parity_err_q;

endmodule
